vdp_vram_arbiter: RTL and testbench
===================================

# vdp_vram_arbiter

Single-port VRAM arbiter for the TMS9918-style VDP. It shares one synchronous 8-bit VRAM between two requesters on the pixel clock domain: the display fetch pipeline, which has absolute priority and can issue back-to-back requests, and the CPU access path behind VDP ports 0x80/0x81. The CPU path is buffered one request deep and serviced in display idle cycles. Starvation and overrun are reported for debug and LEDs.

## Interface
- AW, 14: VRAM address width (16 KiB).
- DW, 8: data width.
- STARVE_LIMIT, 64: number of blocked cycles at which `cpu_starve` asserts (1..255).

- clk  in  1  pixel clock (hwclk, 25 MHz); every register in the block is on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- disp_req  in  1  display fetch request for this cycle.
- disp_addr  in  AW  display fetch address.
- disp_valid  out  1  display read data valid; asserted exactly 1 cycle after a granted `disp_req`.
- disp_rdata  out  DW  display read data, valid while `disp_valid`=1.
- cpu_req  in  1  single-cycle CPU access strobe, already synchronized to `clk`.
- cpu_we  in  1  1 = write, 0 = read; sampled with `cpu_req`.
- cpu_addr  in  AW  CPU address; sampled with `cpu_req`.
- cpu_wdata  in  DW  CPU write data; sampled with `cpu_req`.
- cpu_busy  out  1  a CPU request is latched and not yet completed.
- cpu_done  out  1  1-cycle pulse when the CPU access completes.
- cpu_rdata  out  DW  last CPU read result; updated only on a read `cpu_done`, held otherwise.
- cpu_starve  out  1  pending CPU request has been blocked for at least STARVE_LIMIT cycles.
- cpu_overrun  out  1  sticky flag: a `cpu_req` arrived while `cpu_busy`=1.
- max_wait  out  8  largest observed CPU grant delay in cycles, saturating at 255.
- mem_en  out  1  VRAM access enable.
- mem_we  out  1  VRAM write enable.
- mem_addr  out  AW  VRAM address.
- mem_wdata  out  DW  VRAM write data.
- mem_rdata  in  DW  VRAM read data, registered inside the RAM (1-cycle latency).

## Operation
- State machine has three states:
  - IDLE: no CPU request is held.
  - PEND: a CPU request is latched and waiting for a grant.
  - DONE: the grant was issued last cycle and the result is being returned.
- Request acceptance:
  - In IDLE, or in DONE, `cpu_req`=1 latches addr, we and wdata and moves to PEND.
  - In DONE the new request is latched in the same cycle that `cpu_done` pulses.
  - `cpu_req` in PEND is dropped and sets `cpu_overrun`.
- Grant priority per cycle:
  - If `disp_req`=1, the display owns the port.
  - Otherwise, in PEND, the CPU owns the port.
  - Otherwise the port is idle.
- Port outputs for each owner:
  - Display grant: `mem_en`=1, `mem_we`=0, `mem_addr`=`disp_addr`.
  - CPU grant: `mem_en`=1, `mem_we`=`cpu_we`, `mem_addr` and `mem_wdata` come from the latch; next state is DONE.
  - Idle: `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- The `mem_*` outputs are combinational from state, the latch and `disp_*`.
- DONE:
  - `cpu_done`=1.
  - On a read, `cpu_rdata` <= `mem_rdata`.
  - Next state is PEND if `cpu_req`=1, else IDLE.
- `cpu_busy`=1 in PEND and 0 in IDLE and DONE.
- `disp_valid` is a 1-cycle delay of the display grant (= `disp_req`); `disp_rdata` = `mem_rdata`.
- Wait counter (8 bits, saturating):
  - Cleared on entry to PEND.
  - Increments on each PEND cycle where `disp_req`=1.
  - `cpu_starve` = (PEND and wait ≥ STARVE_LIMIT).
  - On a CPU grant, `max_wait` <= max(`max_wait`, wait).
- Reset:
  - All state and outputs go to 0: state IDLE, latch cleared, `cpu_rdata`=0, `max_wait`=0, `cpu_overrun`=0, `disp_valid`=0.
  - Reset mid-request discards the request with no `cpu_done` and no write.
  - Reset overrides every input in the same cycle.

## Timing
- `cpu_req` at edge t gives `cpu_busy`=1 in cycle t+1.
- The earliest CPU grant is in cycle t+1, so `cpu_done` comes at t+2 at the earliest.
- Each display cycle that blocks the grant adds exactly 1 cycle of latency.
- CPU write: the write occurs in the grant cycle; `cpu_done` follows 1 cycle later.
- CPU read: `cpu_rdata` is valid from the cycle after `cpu_done` and holds until the next read completes.
- Display: data arrives 1 cycle after request with no bubbles; a request every cycle is served every cycle.
- Continuous `disp_req` starves the CPU indefinitely (the display must leave blanking gaps). The wait counter saturates at 255 and does not wrap.
- Minimum CPU issue interval is 2 cycles: request in the DONE cycle, grant in the next cycle.

## Test plan
- Reset, then idle: every output is 0. `cpu_req` write addr 0x1234 data 0xA5 with `disp_req`=0 → `mem_we`=1 at `mem_addr` 0x1234 one cycle after the request, `cpu_done` the cycle after, `max_wait`=0.
- Write 0x3FFF=0x5A, then read 0x3FFF while `disp_req` is held high for 10 cycles → grant in the first cycle after `disp_req` drops; `cpu_rdata`=0x5A; `max_wait`=10.
- Display burst of 8 back-to-back requests to addresses 0x0000..0x0007 with a CPU read pending → `disp_valid` high for 8 consecutive cycles in order, the CPU is granted only afterwards, and no display data is lost.
- Second `cpu_req` while `cpu_busy`=1 → the request is ignored, `cpu_overrun`=1 and stays set; the first request completes normally. A `cpu_req` in the `cpu_done` cycle is accepted and the write lands 1 cycle later.
- `disp_req` held high for 300 cycles with a CPU request pending → `cpu_starve` rises after 64 blocked cycles, the wait counter saturates at 255, and `max_wait`=255 after the grant.
- `reset` asserted while in PEND → no `mem_we` and no `cpu_done`; all outputs are 0 in the next cycle.

Source files
------------

// File: rtl/vdp_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vdp_vram_arbiter
// Purpose  : Single-port VRAM arbiter; display fetch has absolute priority,
//            CPU access is buffered one deep and serviced in display gaps.
// Revision : 1.0 - initial release
// ============================================================================
module vdp_vram_arbiter #(
  parameter int AW           = 14,
  parameter int DW           = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_valid,
  output logic [DW-1:0] disp_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_busy,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_starve,
  output logic          cpu_overrun,
  output logic [7:0]    max_wait,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_lat_we;
  logic [AW-1:0]   r_lat_addr;
  logic [DW-1:0]   r_lat_wdata;
  logic [7:0]      r_wait;
  logic [7:0]      r_max_wait;
  logic            r_overrun;
  logic [DW-1:0]   r_cpu_rdata;
  logic            r_disp_valid;

  logic            w_cpu_grant;
  logic            w_accept;

  assign w_cpu_grant = (r_state == S_PEND) && !disp_req;
  // A new request is accepted whenever nothing is held, including the DONE cycle.
  assign w_accept    = cpu_req && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lat_we     <= 1'b0;
      r_lat_addr   <= '0;
      r_lat_wdata  <= '0;
      r_wait       <= 8'd0;
      r_max_wait   <= 8'd0;
      r_overrun    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_disp_valid <= 1'b0;
    end else begin
      r_disp_valid <= disp_req;

      if (w_accept) begin
        r_lat_we    <= cpu_we;
        r_lat_addr  <= cpu_addr;
        r_lat_wdata <= cpu_wdata;
        r_wait      <= 8'd0;
      end

      case (r_state)
        S_IDLE: begin
          if (cpu_req) r_state <= S_PEND;
        end
        S_PEND: begin
          if (cpu_req) r_overrun <= 1'b1;
          if (disp_req) begin
            if (r_wait != 8'hFF) r_wait <= r_wait + 8'd1;
          end else begin
            if (r_wait > r_max_wait) r_max_wait <= r_wait;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // RAM read latency is one cycle, so grant-cycle data is on mem_rdata now.
          if (!r_lat_we) r_cpu_rdata <= mem_rdata;
          r_state <= cpu_req ? S_PEND : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (disp_req) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else if (w_cpu_grant) begin
        mem_en    = 1'b1;
        mem_we    = r_lat_we;
        mem_addr  = r_lat_addr;
        mem_wdata = r_lat_wdata;
      end
    end
  end

  assign disp_valid  = r_disp_valid;
  assign disp_rdata  = mem_rdata;
  assign cpu_busy    = (r_state == S_PEND);
  assign cpu_done    = (r_state == S_DONE);
  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_starve  = (r_state == S_PEND) && (r_wait >= c_starve_limit);
  assign cpu_overrun = r_overrun;
  assign max_wait    = r_max_wait;

endmodule
`default_nettype wire

// File: tb/tb_vdp_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_vram_arbiter
// Purpose  : Directed self-checking bench for vdp_vram_arbiter with a
//            behavioural 16 KiB synchronous VRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [13:0] disp_addr;
  logic        disp_valid;
  logic [7:0]  disp_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic [7:0]  cpu_rdata;
  logic        cpu_starve;
  logic        cpu_overrun;
  logic [7:0]  max_wait;
  logic        mem_en;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:16383];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  vdp_vram_arbiter #(.AW(14), .DW(8), .STARVE_LIMIT(64)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_rdata(disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_starve(cpu_starve), .cpu_overrun(cpu_overrun), .max_wait(max_wait),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous VRAM with registered read data
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_issue(input logic we, input logic [13:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
    for (int i = 0; i < 8; i++) ram[i] = 8'h10 + 8'(i);
    mem_rdata = 8'h00;
    reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_outputs", {disp_valid, cpu_busy, cpu_done, cpu_starve, cpu_overrun, mem_en, mem_we}, 32'h0);
    check("rst_data", {cpu_rdata, max_wait, mem_wdata}, 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);

    // Uncontended write
    step();
    cpu_issue(1'b1, 14'h1234, 8'hA5);
    #1 check("wr_idle_no_grant", 32'(mem_en), 32'h0);
    step(); cpu_req = 1'b0;
    #1 check("wr_grant", {cpu_busy, mem_en, mem_we, 2'b0, mem_addr, mem_wdata}, {3'b111, 2'b0, 14'h1234, 8'hA5});
    step();
    #1 check("wr_done", {cpu_done, cpu_busy, mem_en}, 3'b100);
    step();
    #1 check("wr_after", {cpu_done, max_wait}, 9'h000);
    check("wr_ram", 32'(ram[14'h1234]), 32'hA5);

    // Write 0x3FFF, then read it back while the display blocks for 10 cycles
    cpu_issue(1'b1, 14'h3FFF, 8'h5A);
    step(); cpu_req = 1'b0;
    step(); step();
    cpu_issue(1'b0, 14'h3FFF, 8'h00);
    step(); cpu_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      disp_req = 1'b1; disp_addr = 14'(i);
      #1;
      if (i == 0 || i == 9)
        check("rd_blocked", {cpu_busy, mem_we, 2'b0, mem_addr}, {2'b10, 2'b0, 14'(i)});
      step();
    end
    disp_req = 1'b0;
    #1 check("rd_grant", {mem_en, mem_we, 2'b0, mem_addr}, {2'b10, 2'b0, 14'h3FFF});
    check("rd_no_starve", 32'(cpu_starve), 32'h0);
    step();
    #1 check("rd_done", 32'(cpu_done), 32'h1);
    step();
    #1 check("rd_data", 32'(cpu_rdata), 32'h5A);
    check("rd_max_wait", 32'(max_wait), 32'd10);

    // Display burst of 8 with a CPU read of 0x1234 pending
    for (int k = 0; k < 8; k++) begin
      disp_req = 1'b1; disp_addr = 14'(k);
      if (k == 0) cpu_issue(1'b0, 14'h1234, 8'h00); else cpu_req = 1'b0;
      #1;
      check("burst_owner", 32'(mem_addr), 32'(k));
      if (k > 0) check("burst_data", {disp_valid, disp_rdata}, {1'b1, 8'h10 + 8'(k - 1)});
      step();
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    #1 check("burst_last", {disp_valid, disp_rdata}, {1'b1, 8'h17});
    check("burst_cpu_grant", {mem_en, mem_we, 2'b0, mem_addr}, {2'b10, 2'b0, 14'h1234});
    step();
    #1 check("burst_done", {cpu_done, disp_valid}, 2'b10);
    step();
    #1 check("burst_rdata", {cpu_rdata, max_wait}, {8'hA5, 8'd10});

    // Overrun: second request while busy is dropped
    cpu_issue(1'b1, 14'h0100, 8'h11);
    step();
    disp_req = 1'b1; disp_addr = 14'h0005;
    cpu_issue(1'b1, 14'h0200, 8'h22);
    #1 check("ovr_busy", {cpu_busy, cpu_overrun}, 2'b10);
    step();
    disp_req = 1'b0; cpu_req = 1'b0;
    #1 check("ovr_flag", 32'(cpu_overrun), 32'h1);
    check("ovr_first_grant", {mem_we, 2'b0, mem_addr, mem_wdata}, {1'b1, 2'b0, 14'h0100, 8'h11});
    step();
    cpu_issue(1'b1, 14'h0300, 8'h33);
    #1 check("ovr_done", 32'(cpu_done), 32'h1);
    step(); cpu_req = 1'b0;
    #1 check("b2b_grant", {cpu_busy, mem_we, 2'b0, mem_addr, mem_wdata}, {2'b11, 2'b0, 14'h0300, 8'h33});
    step(); step();
    #1 check("ovr_sticky", 32'(cpu_overrun), 32'h1);
    check("ovr_ram", {ram[14'h0100], ram[14'h0200], ram[14'h0300]}, {8'h11, 8'h00, 8'h33});

    // Starvation: display holds the port for 300 cycles
    cpu_issue(1'b0, 14'h0300, 8'h00);
    step(); cpu_req = 1'b0;
    for (int j = 0; j < 300; j++) begin
      disp_req = 1'b1; disp_addr = 14'(j);
      #1;
      if (j == 63) check("starve_below", 32'(cpu_starve), 32'h0);
      if (j == 64) check("starve_at", 32'(cpu_starve), 32'h1);
      if (j == 299) check("starve_end", {cpu_starve, cpu_busy}, 2'b11);
      step();
    end
    disp_req = 1'b0;
    #1 check("starve_grant", {mem_en, 2'b0, mem_addr}, {1'b1, 2'b0, 14'h0300});
    step();
    #1 check("starve_max_wait", {cpu_done, max_wait}, {1'b1, 8'd255});
    step();
    #1 check("starve_rdata", 32'(cpu_rdata), 32'h33);

    // Reset while a write is pending and ungranted
    cpu_issue(1'b1, 14'h0400, 8'h44);
    step(); cpu_req = 1'b0;
    reset = 1'b1;
    #1 check("rst_pend_no_we", {mem_en, mem_we, cpu_done}, 3'b000);
    step();
    reset = 1'b0;
    #1 check("rst_pend_flags", {disp_valid, cpu_busy, cpu_done, cpu_starve, cpu_overrun, mem_en, mem_we}, 32'h0);
    check("rst_pend_data", {cpu_rdata, max_wait}, 32'h0);
    step();
    #1 check("rst_pend_after", {cpu_done, mem_en}, 2'b00);
    check("rst_pend_ram", 32'(ram[14'h0400]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
